// File: rtl/kpn_pkg.sv
// Shared constants and helpers for KPN process blocks.
package kpn_pkg;

  localparam int unsigned KPN_WIDTH     = 16;
  localparam int unsigned KPN_DEPTH     = 8;
  localparam int unsigned KPN_N_READERS = 2;

  // Pointer carries one extra wrap bit so full and empty are distinguishable.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/kpn_fifo_reader_port.sv
// One consumer channel of the broadcast FIFO: read pointer, occupancy and underflow.
module kpn_fifo_reader_port
  import kpn_pkg::*;
#(
  parameter int unsigned DEPTH = KPN_DEPTH,
  localparam int unsigned PW   = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [PW-1:0] wptr,
  input  logic          rd,
  output logic [PW-1:0] rptr,
  output logic [PW-1:0] count,
  output logic          empty,
  output logic          underflow
);

  // Modulo-2*DEPTH difference falls out of the PW-bit subtraction.
  assign count = wptr - rptr;
  assign empty = (count == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rptr      <= '0;
      underflow <= 1'b0;
    end else if (rd) begin
      if (empty) underflow <= 1'b1;
      else       rptr      <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/kpn_broadcast_fifo.sv
// Single-producer, multi-consumer broadcast FIFO with shared storage and per-reader pointers.
module kpn_broadcast_fifo
  import kpn_pkg::*;
#(
  parameter int unsigned WIDTH     = KPN_WIDTH,
  parameter int unsigned DEPTH     = KPN_DEPTH,
  parameter int unsigned N_READERS = KPN_N_READERS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr,
  input  logic [WIDTH-1:0]           entry_1,
  output logic                       full,
  input  logic [N_READERS-1:0]       rd,
  output logic [N_READERS*WIDTH-1:0] output_1,
  output logic [N_READERS-1:0]       empty,
  output logic                       overflow,
  output logic [N_READERS-1:0]       underflow
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned AW = PW - 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr  [N_READERS];
  logic [PW-1:0]    count [N_READERS];
  logic             wr_en;

  for (genvar k = 0; k < N_READERS; k++) begin : g_port
    kpn_fifo_reader_port #(.DEPTH(DEPTH)) u_port (
      .clk       (clk),
      .reset     (reset),
      .wptr      (wptr),
      .rd        (rd[k]),
      .rptr      (rptr[k]),
      .count     (count[k]),
      .empty     (empty[k]),
      .underflow (underflow[k])
    );
  end

  // Full tracks the slowest reader; a same-cycle pop never frees room for this write.
  always_comb begin
    full = 1'b0;
    for (int unsigned k = 0; k < N_READERS; k++) begin
      if (count[k] == PW'(DEPTH)) full = 1'b1;
    end
  end

  assign wr_en = wr & ~full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr     <= '0;
      overflow <= 1'b0;
    end else if (wr) begin
      if (full) overflow <= 1'b1;
      else      wptr     <= wptr + 1'b1;
    end
  end

  // No reset on storage so it can map onto RAM primitives.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[AW-1:0]] <= entry_1;
  end

  always_comb begin
    output_1 = '0;
    for (int unsigned k = 0; k < N_READERS; k++) begin
      if (!empty[k]) output_1[k*WIDTH +: WIDTH] = mem[rptr[k][AW-1:0]];
    end
  end

endmodule

// File: tb/tb_kpn_broadcast_fifo.sv
// Directed bench for kpn_broadcast_fifo with a queue-based reference model.
module tb_kpn_broadcast_fifo;

  typedef logic [15:0] word_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr = 1'b0;
  word_t       entry = '0;
  logic [1:0]  rd2 = '0;
  logic [2:0]  rd3 = '0;

  logic        f2, ovf2, f3, ovf3;
  logic [31:0] o2;
  logic [47:0] o3;
  logic [1:0]  e2, unf2;
  logic [2:0]  e3, unf3;

  int total = 0;
  int bad = 0;
  bit chk_on = 0;

  always #5 clk = ~clk;

  kpn_broadcast_fifo dut (
    .clk(clk), .reset(reset), .wr(wr), .entry_1(entry), .full(f2), .rd(rd2),
    .output_1(o2), .empty(e2), .overflow(ovf2), .underflow(unf2)
  );

  kpn_broadcast_fifo #(.N_READERS(3)) dut3 (
    .clk(clk), .reset(reset), .wr(wr), .entry_1(entry), .full(f3), .rd(rd3),
    .output_1(o3), .empty(e3), .overflow(ovf3), .underflow(unf3)
  );

  // Reference model: one queue of unread words per reader.
  word_t q2 [2][$];
  word_t q3 [3][$];
  logic       m_ovf2, m_ovf3;
  logic [1:0] m_unf2;
  logic [2:0] m_unf3;

  function automatic bit full2_m();
    for (int k = 0; k < 2; k++) if (q2[k].size() == 8) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit full3_m();
    for (int k = 0; k < 3; k++) if (q3[k].size() == 8) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) q2[k].delete();
      for (int k = 0; k < 3; k++) q3[k].delete();
      m_ovf2 <= 1'b0; m_ovf3 <= 1'b0; m_unf2 <= '0; m_unf3 <= '0;
    end else begin
      bit fl2, fl3;
      fl2 = full2_m();
      fl3 = full3_m();
      for (int k = 0; k < 2; k++)
        if (rd2[k]) begin
          if (q2[k].size() == 0) m_unf2[k] <= 1'b1;
          else void'(q2[k].pop_front());
        end
      for (int k = 0; k < 3; k++)
        if (rd3[k]) begin
          if (q3[k].size() == 0) m_unf3[k] <= 1'b1;
          else void'(q3[k].pop_front());
        end
      if (wr) begin
        if (fl2) m_ovf2 <= 1'b1;
        else for (int k = 0; k < 2; k++) q2[k].push_back(entry);
        if (fl3) m_ovf3 <= 1'b1;
        else for (int k = 0; k < 3; k++) q3[k].push_back(entry);
      end
    end
  end

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] at %0t: got 0x%0h expected 0x%0h", name, idx, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("cmp_full2", 0, 64'(f2), 64'(full2_m()));
      chk("cmp_ovf2", 0, 64'(ovf2), 64'(m_ovf2));
      chk("cmp_full3", 0, 64'(f3), 64'(full3_m()));
      chk("cmp_ovf3", 0, 64'(ovf3), 64'(m_ovf3));
      for (int k = 0; k < 2; k++) begin
        chk("cmp_empty2", k, 64'(e2[k]), 64'(q2[k].size() == 0));
        chk("cmp_data2", k, 64'(o2[k*16 +: 16]), 64'((q2[k].size() == 0) ? 16'h0 : q2[k][0]));
        chk("cmp_unf2", k, 64'(unf2[k]), 64'(m_unf2[k]));
      end
      for (int k = 0; k < 3; k++) begin
        chk("cmp_empty3", k, 64'(e3[k]), 64'(q3[k].size() == 0));
        chk("cmp_data3", k, 64'(o3[k*16 +: 16]), 64'((q3[k].size() == 0) ? 16'h0 : q3[k][0]));
        chk("cmp_unf3", k, 64'(unf3[k]), 64'(m_unf3[k]));
      end
    end
  end

  task automatic cyc(input logic w, input word_t d, input logic [1:0] r2, input logic [2:0] r3);
    wr = w; entry = d; rd2 = r2; rd3 = r3;
    @(negedge clk);
    wr = 1'b0; rd2 = '0; rd3 = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int n [3];
    int wrote;
    bit w;
    logic [2:0] r;

    repeat (2) @(negedge clk);
    chk("rst_empty", 0, 64'(e2), 64'(2'b11));
    chk("rst_out", 0, 64'(o2), 64'(0));
    chk("rst_flags", 0, 64'({f2, ovf2, unf2}), 64'(0));
    reset = 1'b0;
    chk_on = 1'b1;

    // Three writes, no pops: every reader sees the first word.
    for (int i = 1; i <= 3; i++) cyc(1'b1, word_t'(i), 2'b00, 3'b000);
    chk("w3_empty", 0, 64'(e2), 64'(2'b00));
    chk("w3_out", 0, 64'(o2), 64'({16'h0001, 16'h0001}));
    chk("w3_full", 0, 64'(f2), 64'(0));

    // Reader 0 drains while reader 1 idles until it holds DEPTH words.
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b1, word_t'(i + 1), (i > 0) ? 2'b01 : 2'b00, 3'b000);
    chk("fill_full", 0, 64'(f2), 64'(1));
    chk("fill_out", 0, 64'(o2), 64'({16'h0001, 16'h0008}));
    cyc(1'b1, 16'h0009, 2'b00, 3'b000);
    chk("drop_ovf", 0, 64'(ovf2), 64'(1));
    chk("drop_full", 0, 64'(f2), 64'(1));
    for (int i = 0; i < 8; i++) begin
      chk("r1_order", i, 64'(o2[31:16]), 64'(i + 1));
      cyc(1'b0, '0, 2'b10, 3'b000);
    end
    chk("r1_drained", 0, 64'(e2), 64'(2'b10));

    // Pop on an empty reader is ignored and flagged.
    cyc(1'b0, '0, 2'b10, 3'b000);
    chk("unf_flag", 0, 64'(unf2), 64'(2'b10));
    chk("unf_out", 0, 64'(o2), 64'({16'h0000, 16'h0008}));
    cyc(1'b1, 16'h0055, 2'b00, 3'b000);
    chk("unf_rptr", 0, 64'(o2[31:16]), 64'(16'h0055));
    chk("sticky_ovf", 0, 64'(ovf2), 64'(1));

    // Full with write and both pops: write dropped, pops taken.
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b1, word_t'(16'h10 + i), 2'b00, 3'b000);
    chk("full8", 0, 64'(f2), 64'(1));
    cyc(1'b1, 16'h00FF, 2'b11, 3'b000);
    chk("sim_ovf", 0, 64'(ovf2), 64'(1));
    chk("sim_full", 0, 64'(f2), 64'(0));
    chk("sim_out", 0, 64'(o2), 64'({16'h0011, 16'h0011}));

    // Wrap-around on the 3-reader instance, readers at different rates.
    do_reset();
    wrote = 0;
    for (int k = 0; k < 3; k++) n[k] = 0;
    for (int c = 0; c < 300; c++) begin
      if (n[0] == 20 && n[1] == 20 && n[2] == 20) break;
      w = (wrote < 20) && !full3_m();
      r = '0;
      for (int k = 0; k < 3; k++)
        if (q3[k].size() != 0 && (c % (k + 1)) == 0) begin
          r[k] = 1'b1;
          chk("wrap_order", k, 64'(o3[k*16 +: 16]), 64'(16'h0100 + n[k]));
          n[k]++;
        end
      cyc(w, word_t'(16'h0100 + wrote), 2'b00, r);
      if (w) wrote++;
    end
    for (int k = 0; k < 3; k++) chk("wrap_count", k, 64'(n[k]), 64'(20));
    chk("wrap_unf", 0, 64'(unf3), 64'(0));

    // Asynchronous reset with words queued.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, word_t'(16'h20 + i), 2'b01, 3'b000);
    cyc(1'b0, '0, 2'b01, 3'b000);
    cyc(1'b0, '0, 2'b01, 3'b000);
    chk("pre_unf", 0, 64'(unf2), 64'(2'b01));
    chk("pre_empty", 0, 64'(e3), 64'(3'b000));
    #2 reset = 1'b1;
    #1;
    chk("arst_empty2", 0, 64'(e2), 64'(2'b11));
    chk("arst_out2", 0, 64'(o2), 64'(0));
    chk("arst_flags2", 0, 64'({f2, ovf2, unf2}), 64'(0));
    chk("arst_empty3", 0, 64'(e3), 64'(3'b111));
    chk("arst_out3", 0, 64'(o3), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    cyc(1'b1, 16'h00AB, 2'b00, 3'b000);
    chk("post_rst_out", 0, 64'(o2), 64'({16'h00AB, 16'h00AB}));
    chk("post_rst_empty", 0, 64'(e2), 64'(2'b00));

    @(negedge clk);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/kpn_broadcast_fifo.md
KPN_BROADCAST_FIFO -- requirements
Module: kpn_broadcast_fifo

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits.
REQ-002 Parameter DEPTH, default 8, entries of storage; power of two, >= 2.
REQ-003 Parameter N_READERS, default 2, number of independent consumer channels.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 wr  input  1  producer write request.
REQ-007 entry_1  input  WIDTH  producer data word.
REQ-008 full  output  1  high when any reader holds DEPTH unread words.
REQ-009 rd  input  N_READERS  per-reader pop request, bit k = reader k.
REQ-010 output_1  output  N_READERS*WIDTH  head word for reader k in slice [k*WIDTH +: WIDTH].
REQ-011 empty  output  N_READERS  bit k high when reader k has no unread word.
REQ-012 overflow  output  1  sticky flag: write attempted while full.
REQ-013 underflow  output  N_READERS  sticky flag per reader: pop attempted while empty.

Function
REQ-014 The block SHALL broadcast every accepted word to all N_READERS channels in write order, each reader consuming at its own rate.
REQ-015 Storage SHALL be one shared DEPTH x WIDTH array, one write pointer, and one read pointer per reader, each log2(DEPTH)+1 bits (extra wrap bit).
REQ-016 count_k SHALL equal (wptr - rptr_k) modulo 2*DEPTH; empty[k] = (count_k == 0); full = (max over k of count_k == DEPTH).
REQ-017 A write SHALL be accepted iff wr is high and full is low at the sampling edge; accepted data stored at mem[wptr], wptr incremented with wrap.
REQ-018 A write with full high SHALL be dropped, leave state unchanged, and set overflow; no bypass even if the slowest reader pops the same cycle.
REQ-019 A pop by reader k SHALL be accepted iff rd[k] is high and empty[k] is low at the sampling edge; rptr_k incremented with wrap.
REQ-020 A pop with empty[k] high SHALL be ignored and set underflow[k]; a same-cycle write does not satisfy it.
REQ-021 Output is first-word-fall-through: output_1 slice k SHALL equal mem[rptr_k] while empty[k] is low, and all zeros while empty[k] is high.
REQ-022 Write latency: a word accepted at edge n SHALL appear on an empty reader's slice, with empty[k] low, after edge n.
REQ-023 Simultaneous write and pops SHALL all take effect in the same edge; a reader's pop never blocks another reader's progress.
REQ-024 A storage slot SHALL be rewritten only after every reader has popped it (guaranteed by REQ-016/018).
REQ-025 Sticky flags SHALL stay set until reset.

Reset
REQ-026 Assertion of reset SHALL immediately clear wptr, all rptr_k, overflow, and underflow, forcing empty all ones, full low, output_1 all zeros, regardless of clock.
REQ-027 Reset mid-operation SHALL discard all unread words; memory contents need not be cleared.
REQ-028 First write SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-029 Default WIDTH/DEPTH/N_READERS constants and the pointer-width function SHALL live in shared package kpn_pkg, reused by other KPN processes.
REQ-030 Per-reader pointer, empty, count and underflow logic SHALL be one sub-module kpn_fifo_reader_port, instantiated N_READERS times via generate.
REQ-031 Implementation SHALL be synthesizable for the team's FPGA with memory inferable as distributed or block RAM.

Verification
REQ-032 Reset, write 0x0001..0x0003, no pops -> empty = 2'b00, both slices show 0x0001, full low.
REQ-033 DEPTH=8, 8 writes with reader 0 popping every cycle and reader 1 idle -> full high after 8th write; 9th write dropped, overflow set, reader 1 later pops 0x0001..0x0008 in order.
REQ-034 Pop reader 1 while empty[1] high -> underflow[1] set, rptr_1 unchanged, output slice 1 stays 0.
REQ-035 Full FIFO, wr and rd = 2'b11 same cycle -> write dropped with overflow set, both pops accepted, full low next cycle.
REQ-036 Wrap-around: 20 writes interleaved with pops for N_READERS=3 -> every reader sees 20 words in order, no loss or duplication.
REQ-037 Assert reset asynchronously mid-stream with 5 words queued -> outputs clear before next clock edge, empty all ones, flags cleared.
